// File: rtl/mod_counter_pkg.sv
// Shared constants and types for the modulo up/down counter and its prescaler.
package mod_counter_pkg;

    // Boundary behaviour selected by the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Prescaler counter width; covers every legal PRESCALE up to 65535
    localparam int PRESCALE_W = 16;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_CLR  = 2'd1,
        ACT_LOAD = 2'd2,
        ACT_STEP = 2'd3
    } action_e;

endpackage

// File: rtl/mod_counter_prescale.sv
// Enable prescaler: raises tick on the enabled cycle that completes PRESCALE enabled cycles.
module mod_counter_prescale
    import mod_counter_pkg::*;
#(
    parameter int PRESCALE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PRESCALE_W'(1);
        end
    end

    // restart (clr/load) wins over a step that would otherwise land this cycle
    assign tick = en && !restart && (cnt == LAST);

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with prescaled enable, wrap or saturate bounds, tc pulse and sticky ovf.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int PRESCALE = 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    // MODULUS-1 always fits in WIDTH bits, so no wider intermediate is needed
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam bit               SAT  = (SATURATE == MODE_SAT);

    logic             step_tick;
    action_e          act;
    logic             at_bound;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamp;

    generate
        if (PRESCALE == 1) begin : g_no_prescale
            assign step_tick = en;
        end else begin : g_prescale
            mod_counter_prescale #(
                .PRESCALE (PRESCALE)
            ) u_prescale (
                .clk     (clk),
                .reset   (reset),
                .en      (en),
                .restart (clr | load),
                .tick    (step_tick)
            );
        end
    endgenerate

    always_comb begin
        act = ACT_HOLD;
        if (clr) begin
            act = ACT_CLR;
        end else if (load) begin
            act = ACT_LOAD;
        end else if (step_tick) begin
            act = ACT_STEP;
        end
    end

    always_comb begin
        at_bound = up ? (out == MAXV) : (out == '0);
        step_val = out;
        if (up) begin
            if (at_bound) begin
                step_val = SAT ? MAXV : '0;
            end else begin
                step_val = out + WIDTH'(1);
            end
        end else begin
            if (at_bound) begin
                step_val = SAT ? '0 : MAXV;
            end else begin
                step_val = out - WIDTH'(1);
            end
        end
        load_clamp = (load_val > MAXV) ? MAXV : load_val;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            case (act)
                ACT_CLR: begin
                    out <= '0;
                    tc  <= 1'b0;
                    ovf <= 1'b0;
                end
                ACT_LOAD: begin
                    out <= load_clamp;
                    tc  <= 1'b0;
                end
                ACT_STEP: begin
                    out <= step_val;
                    tc  <= at_bound;
                    ovf <= ovf | at_bound;
                end
                default: begin
                    tc <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Directed scoreboard bench for mod_counter across wrap, saturate, prescale and full-range builds.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, up, clr, load;
    logic [7:0] load_val;

    logic [7:0] out_a, out_b, out_c, out_d;
    logic       tc_a, tc_b, tc_c, tc_d;
    logic       ovf_a, ovf_b, ovf_c, ovf_d;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] o;
        logic       t;
        logic       v;
    } exp_t;

    exp_t sb[$];

    always #10 clk = ~clk;

    mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .out(out_a), .tc(tc_a), .ovf(ovf_a));
    mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .out(out_b), .tc(tc_b), .ovf(ovf_b));
    mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .out(out_c), .tc(tc_c), .ovf(ovf_c));
    mod_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1), .SATURATE(0)) u_d (
        .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .out(out_d), .tc(tc_d), .ovf(ovf_d));

    function automatic logic [9:0] obs(input int s);
        case (s)
            0:       return {out_a, tc_a, ovf_a};
            1:       return {out_b, tc_b, ovf_b};
            2:       return {out_c, tc_c, ovf_c};
            default: return {out_d, tc_d, ovf_d};
        endcase
    endfunction

    task automatic chk8(input string tag, input logic [7:0] o, input logic [7:0] x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, x);
        end
    endtask

    task automatic chk1(input string tag, input logic o, input logic x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, x);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [7:0] o,
                        input logic t, input logic v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.o   = o;
        e.t   = t;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t       e;
        logic [9:0] ob;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            ob = obs(e.sel);
            chk8({e.tag, "_out"}, ob[9:2], e.o);
            chk1({e.tag, "_tc"},  ob[1],   e.t);
            chk1({e.tag, "_ovf"}, ob[0],   e.v);
        end
    endtask

    task automatic drive(input logic e_i, input logic u_i, input logic c_i,
                         input logic l_i, input logic [7:0] lv_i);
        en       = e_i;
        up       = u_i;
        clr      = c_i;
        load     = l_i;
        load_val = lv_i;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(0, 1, 0, 0, 8'd0);
        #3;
        chk8("rst_out_a", out_a, 8'd0);
        chk1("rst_tc_a", tc_a, 1'b0);
        chk1("rst_ovf_a", ovf_a, 1'b0);
        chk8("rst_out_d", out_d, 8'd0);
        #12;
        reset = 1'b0;

        // Wrap up, modulus 10
        drive(0, 1, 1, 0, 8'd0);
        push("wrap_clr", 0, 8'd0, 1'b0, 1'b0);
        tick();
        drive(1, 1, 0, 0, 8'd0);
        for (int i = 0; i < 12; i++) begin
            push($sformatf("wrap%0d", i), 0, 8'((i + 1) % 10), i == 9, i >= 9);
            tick();
        end

        // Saturate down from a load of 2
        drive(0, 1, 1, 0, 8'd0);
        push("sat_clr", 1, 8'd0, 1'b0, 1'b0);
        tick();
        drive(0, 1, 0, 1, 8'd2);
        push("sat_load", 1, 8'd2, 1'b0, 1'b0);
        tick();
        drive(1, 0, 0, 0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            push($sformatf("sat%0d", i), 1, (i == 0) ? 8'd1 : 8'd0, i >= 2, i >= 2);
            tick();
        end
        drive(0, 0, 0, 0, 8'd0);
        push("sat_idle", 1, 8'd0, 1'b0, 1'b1);
        tick();

        // Prescale by 3, enable gap, direction change mid-prescale
        drive(0, 1, 1, 0, 8'd0);
        push("pre_clr", 2, 8'd0, 1'b0, 1'b0);
        tick();
        drive(1, 1, 0, 0, 8'd0);
        for (int i = 0; i < 9; i++) begin
            push($sformatf("pre%0d", i), 2, 8'((i + 1) / 3), 1'b0, 1'b0);
            tick();
        end
        push("gap0", 2, 8'd3, 1'b0, 1'b0); tick();
        drive(0, 1, 0, 0, 8'd0);
        push("gap1", 2, 8'd3, 1'b0, 1'b0); tick();
        push("gap2", 2, 8'd3, 1'b0, 1'b0); tick();
        drive(1, 1, 0, 0, 8'd0);
        push("gap3", 2, 8'd3, 1'b0, 1'b0); tick();
        push("gap4", 2, 8'd4, 1'b0, 1'b0); tick();
        push("dir0", 2, 8'd4, 1'b0, 1'b0); tick();
        drive(1, 0, 0, 0, 8'd0);
        push("dir1", 2, 8'd4, 1'b0, 1'b0); tick();
        push("dir2", 2, 8'd3, 1'b0, 1'b0); tick();

        // Priority: clr over load over step, load clamp
        drive(0, 1, 1, 0, 8'd0);
        push("pri_clr", 0, 8'd0, 1'b0, 1'b0); tick();
        drive(0, 1, 0, 1, 8'd9);
        push("pri_ld9", 0, 8'd9, 1'b0, 1'b0); tick();
        drive(1, 1, 0, 0, 8'd0);
        push("pri_wrap", 0, 8'd0, 1'b1, 1'b1); tick();
        drive(1, 1, 0, 1, 8'd3);
        push("pri_ld_keep_ovf", 0, 8'd3, 1'b0, 1'b1); tick();
        drive(1, 1, 1, 1, 8'd5);
        push("pri_clr_ld", 0, 8'd0, 1'b0, 1'b0); tick();
        drive(0, 1, 0, 1, 8'd200);
        push("pri_clamp", 0, 8'd9, 1'b0, 1'b0); tick();

        // Asynchronous reset mid-count and mid-prescale
        drive(0, 1, 1, 0, 8'd0);
        push("ar_clr_a", 0, 8'd0, 1'b0, 1'b0);
        push("ar_clr_c", 2, 8'd0, 1'b0, 1'b0);
        tick();
        drive(0, 1, 0, 1, 8'd6);
        push("ar_ld_a", 0, 8'd6, 1'b0, 1'b0);
        push("ar_ld_c", 2, 8'd6, 1'b0, 1'b0);
        tick();
        drive(1, 1, 0, 0, 8'd0);
        push("ar_pre_a", 0, 8'd7, 1'b0, 1'b0);
        push("ar_pre_c", 2, 8'd6, 1'b0, 1'b0);
        tick();
        drive(0, 1, 0, 0, 8'd0);
        #1;
        reset = 1'b1;
        #1;
        chk8("ar_out_a", out_a, 8'd0);
        chk1("ar_tc_a", tc_a, 1'b0);
        chk1("ar_ovf_a", ovf_a, 1'b0);
        chk8("ar_out_c", out_c, 8'd0);
        #10;
        reset = 1'b0;
        drive(1, 1, 0, 0, 8'd0);
        push("ar_run0_a", 0, 8'd1, 1'b0, 1'b0);
        push("ar_run0_c", 2, 8'd0, 1'b0, 1'b0);
        tick();
        push("ar_run1_a", 0, 8'd2, 1'b0, 1'b0);
        push("ar_run1_c", 2, 8'd0, 1'b0, 1'b0);
        tick();
        push("ar_run2_a", 0, 8'd3, 1'b0, 1'b0);
        push("ar_run2_c", 2, 8'd1, 1'b0, 1'b0);
        tick();

        // Full 8-bit range, modulus 256
        drive(0, 1, 1, 0, 8'd0);
        push("full_clr", 3, 8'd0, 1'b0, 1'b0); tick();
        drive(1, 0, 0, 0, 8'd0);
        push("full_dn0", 3, 8'd255, 1'b1, 1'b1); tick();
        checks++;
        assert (!$isunknown({out_d, tc_d, ovf_d})) else begin
            errors++;
            $error("FAIL full_noX observed=%b expected=no X", {out_d, tc_d, ovf_d});
        end
        push("full_dn1", 3, 8'd254, 1'b0, 1'b1); tick();
        drive(1, 1, 0, 0, 8'd0);
        push("full_up0", 3, 8'd255, 1'b0, 1'b1); tick();
        push("full_up1", 3, 8'd0, 1'b1, 1'b1); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: bit width of the count output.
REQ-002 The block SHALL take parameter MODULUS, default 256: count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 The block SHALL take parameter PRESCALE, default 1: number of enabled cycles per count step, legal range 1..65535.
REQ-004 The block SHALL take parameter SATURATE, default 0: 0 = wrap at the bounds, 1 = hold at the bounds.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: count enable.
REQ-008 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-009 The block SHALL have port clr, input, 1 bit: synchronous clear.
REQ-010 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-011 The block SHALL have port load_val, input, WIDTH bits: value to load.
REQ-012 The block SHALL have port out, output, WIDTH bits: current count, registered.
REQ-013 The block SHALL have port tc, output, 1 bit: terminal-count pulse, registered.
REQ-014 The block SHALL have port ovf, output, 1 bit: sticky overflow/underflow flag, registered.

Function
REQ-015 On each clock edge, actions SHALL take priority in this order: clr, then load, then count step.
REQ-016 clr=1 SHALL set out=0, ovf=0 and tc=0, and zero the prescaler, regardless of all other inputs.
REQ-017 load=1 with clr=0 SHALL set out=min(load_val, MODULUS-1), zero the prescaler, set tc=0 and leave ovf unchanged.
REQ-018 A step SHALL occur when en=1, clr=0, load=0 and prescaler==PRESCALE-1; the prescaler then returns to 0.
REQ-019 When en=1 without a step, the prescaler SHALL increment; en=0 SHALL hold both the prescaler and out.
REQ-020 PRESCALE=1 SHALL give one step on every cycle with en=1 (no prescaler state needed).
REQ-021 A step with up=1 SHALL give out+1; from MODULUS-1 it SHALL wrap to 0 (SATURATE=0) or hold at MODULUS-1 (SATURATE=1).
REQ-022 A step with up=0 SHALL give out-1; from 0 it SHALL wrap to MODULUS-1 (SATURATE=0) or hold at 0 (SATURATE=1).
REQ-023 A boundary event (a step taken from the terminal value in the current direction) SHALL set tc=1 for exactly the following cycle and set ovf=1.
REQ-024 tc SHALL be 0 on every cycle not immediately after a boundary event.
REQ-025 Back-to-back boundary events in saturate mode SHALL keep tc high for each qualifying step.
REQ-026 ovf SHALL stay high until clr or reset.
REQ-027 A direction change mid-prescale SHALL take effect on the next step without resetting the prescaler.
REQ-028 All arithmetic SHALL be WIDTH bits wide, with the bound compare against MODULUS-1; no intermediate overflow is allowed when MODULUS=2**WIDTH.

Reset
REQ-029 reset=1 SHALL immediately and asynchronously force out=0, tc=0, ovf=0 and prescaler=0.
REQ-030 After reset is released, counting SHALL resume on the first clock edge that meets REQ-018; reset asserted mid-prescale SHALL discard the partial prescale.

Structure
REQ-031 Mode encodings (SATURATE values) and the PRESCALE width constant SHALL live in a shared package/header, mod_counter_pkg.
REQ-032 The prescaler SHALL be one sub-module, mod_counter_prescale (inputs clk, reset, en, restart; output tick), elaborated out when PRESCALE=1.
REQ-033 The block SHALL contain no latches and no combinational paths from inputs to outputs.

Verification
REQ-034 The bench SHALL cover wrap up: WIDTH=8, MODULUS=10, PRESCALE=1, up=1, en=1 for 12 cycles -> out 0..9,0,1; tc=1 only in the cycle after 9->0; ovf=1 from then on.
REQ-035 The bench SHALL cover saturate down: SATURATE=1, load 2, up=0, en=1 for 5 cycles -> out 2,1,0,0,0; tc high on both held steps; ovf=1.
REQ-036 The bench SHALL cover the prescaler: PRESCALE=3, en=1 for 9 cycles -> out steps 0->1->2->3, one step every 3 cycles; en low for 2 cycles mid-prescale -> timing shifts by exactly 2 cycles.
REQ-037 The bench SHALL cover priority: clr=1 and load=1 with load_val=5 on the same edge -> out=0, ovf=0; load_val=200 with MODULUS=10 -> out=9.
REQ-038 The bench SHALL cover asynchronous reset: pulse reset for 11 ns between clock edges while out=7 -> out=0 immediately (before the next edge), tc=0, ovf=0; counting restarts from 0.
REQ-039 The bench SHALL cover a full range check: MODULUS=256, up=0 from 0 -> out=255, tc pulse, no X on any output.
